blowfish_round_sequencer: RTL and testbench

Iterative Blowfish encryption controller. It accepts one 64-bit block over a valid/ready handshake and runs the 16 Feistel rounds by time-sharing a single external F-function unit (`f_module`). It applies the P-array whitening and the output swap, then returns the ciphertext over a second valid/ready handshake. It sits between the block-level input FIFO and the cipher output register, and owns all round sequencing for the encryption datapath.

---
 rtl/blowfish_pkg.sv | 19 +
 rtl/blowfish_p_rom.sv | 15 +
 rtl/blowfish_round_sequencer.sv | 87 ++++++++
 tb/tb_blowfish_round_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish_pkg.sv
// Shared Blowfish constants and the round-sequencer state encoding.
package blowfish_pkg;

    localparam int BLOCK_W    = 64;
    localparam int HALF_W     = 32;
    localparam int ROUNDS_DEF = 16;

    // Initial P-array: hexadecimal digits of pi.
    localparam logic [HALF_W-1:0] P_INIT [0:17] = '{
        32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344,
        32'ha4093822, 32'h299f31d0, 32'h082efa98, 32'hec4e6c89,
        32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
        32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917,
        32'h9216d5d9, 32'h8979fb1b
    };

    typedef enum logic [2:0] {IDLE, LOADF, WAITF, FINAL, DONE} state_t;

endpackage

// File: rtl/blowfish_p_rom.sv
// Combinational P-array lookup; indices above 17 read as zero.
module blowfish_p_rom
    import blowfish_pkg::*;
(
    input  logic [4:0]        idx,
    output logic [HALF_W-1:0] pVal
);

    always_comb begin
        pVal = '0;
        for (int k = 0; k < 18; k++)
            if (idx == 5'(k)) pVal = P_INIT[k];
    end

endmodule

// File: rtl/blowfish_round_sequencer.sv
// Iterative Blowfish encryptor: 16 Feistel rounds time-sharing one external F unit.
module blowfish_round_sequencer
    import blowfish_pkg::*;
#(
    parameter int F_LAT  = 1,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic [HALF_W-1:0]  f_in,
    input  logic [HALF_W-1:0]  f_out,
    output logic               busy
);

    state_t            state;
    logic [HALF_W-1:0] l, r;
    logic [4:0]        idx;
    logic [1:0]        waitCnt;
    logic [HALF_W-1:0] pRound;
    logic [HALF_W-1:0] lWhite;

    blowfish_p_rom uRom (.idx(idx), .pVal(pRound));

    assign lWhite = l ^ pRound;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            l         <= '0;
            r         <= '0;
            idx       <= '0;
            waitCnt   <= '0;
            f_in      <= '0;
            out_block <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    l        <= in_block[63:32];
                    r        <= in_block[31:0];
                    idx      <= '0;
                    state    <= LOADF;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                LOADF: begin
                    l       <= lWhite;
                    f_in    <= lWhite;
                    waitCnt <= 2'(F_LAT - 1);
                    state   <= WAITF;
                end
                WAITF: begin
                    if (waitCnt != 2'd0) begin
                        waitCnt <= waitCnt - 2'd1;
                    end else begin
                        l   <= r ^ f_out;
                        r   <= l;
                        idx <= idx + 5'd1;
                        state <= (idx < 5'(ROUNDS - 1)) ? LOADF : FINAL;
                    end
                end
                // Registers still hold the swapped halves, so r is the true xL here.
                FINAL: begin
                    out_block <= {r ^ P_INIT[17], l ^ P_INIT[16]};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish_round_sequencer.sv
// Directed bench: three sequencers (F_LAT 1/2/4) share stimulus; DUT1 carries most checks.
module tb_blowfish_round_sequencer;

    localparam logic [31:0] PB [0:17] = '{
        32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344,
        32'ha4093822, 32'h299f31d0, 32'h082efa98, 32'hec4e6c89,
        32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
        32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917,
        32'h9216d5d9, 32'h8979fb1b
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_block;
    logic        zeroF;

    logic        in_ready1, out_valid1, busy1;
    logic [63:0] out_block1;
    logic [31:0] f_in1, f_out1;
    logic        in_ready2, out_valid2, busy2;
    logic [63:0] out_block2;
    logic [31:0] f_in2, f_out2;
    logic        in_ready4, out_valid4, busy4;
    logic [63:0] out_block4;
    logic [31:0] f_in4, f_out4;
    logic [31:0] d4 [0:2];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // F stubs: identity delayed by F_LAT-1 registers (F_LAT=1 is combinational).
    assign f_out1 = zeroF ? 32'h0 : f_in1;
    always_ff @(posedge clk) f_out2 <= f_in2;
    always_ff @(posedge clk) begin
        d4[0] <= f_in4;
        d4[1] <= d4[0];
        d4[2] <= d4[1];
    end
    assign f_out4 = d4[2];

    blowfish_round_sequencer #(.F_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_block(in_block), .out_valid(out_valid1), .out_ready(out_ready),
        .out_block(out_block1), .f_in(f_in1), .f_out(f_out1), .busy(busy1));
    blowfish_round_sequencer #(.F_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_block(in_block), .out_valid(out_valid2), .out_ready(out_ready),
        .out_block(out_block2), .f_in(f_in2), .f_out(f_out2), .busy(busy2));
    blowfish_round_sequencer #(.F_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_block(in_block), .out_valid(out_valid4), .out_ready(out_ready),
        .out_block(out_block4), .f_in(f_in4), .f_out(f_out4), .busy(busy4));

    // Textbook Blowfish encryption with F(x) = x (or F = 0).
    function automatic logic [63:0] golden(input logic [63:0] blk, input bit fZero);
        logic [31:0] xl, xr, t;
        xl = blk[63:32];
        xr = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            xl = xl ^ PB[i];
            xr = xr ^ (fZero ? 32'h0 : xl);
            t = xl; xl = xr; xr = t;
        end
        t = xl; xl = xr; xr = t;
        xr = xr ^ PB[16];
        xl = xl ^ PB[17];
        return {xl, xr};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one block to idle DUT1; n = cycles from the accept cycle to first out_valid.
    task automatic runOne(input logic [63:0] blk, output int n);
        in_block = blk;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid1 && n < 400) begin
            step();
            n++;
        end
    endtask

    logic [63:0] blk, expA, ob1, ob2, ob4;
    logic [31:0] oddX, evenX;
    int n, lat1, lat2, lat4, k, m, cyc;
    int acc [0:3];
    logic [63:0] expQ [0:3];

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0; zeroF = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_in_ready", 64'(in_ready1), 64'd1);
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_out_block", out_block1, 64'd0);
        check("rst_f_in", 64'(f_in1), 64'd0);

        // F = 0, zero plaintext: result is pure whitening parity.
        oddX = '0; evenX = '0;
        for (int i = 0; i < 18; i++)
            if (i % 2 == 1) oddX ^= PB[i]; else evenX ^= PB[i];
        out_ready = 1'b1;
        runOne(64'h0, n);
        check("zero_latency", 64'(n), 64'd34);
        check("zero_block", out_block1, {oddX, evenX});
        step();
        check("zero_busy_clear", 64'(busy1), 64'd0);
        check("zero_in_ready", 64'(in_ready1), 64'd1);
        repeat (100) step();

        // Latency / data sweep over F_LAT 1, 2, 4 with identity F.
        zeroF = 1'b0;
        for (int t = 0; t < 2; t++) begin
            blk = {$urandom, $urandom};
            expA = golden(blk, 1'b0);
            in_block = blk;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n = 1; lat1 = 0; lat2 = 0; lat4 = 0;
            while ((lat1 == 0 || lat2 == 0 || lat4 == 0) && n < 200) begin
                if (out_valid1 && lat1 == 0) begin lat1 = n; ob1 = out_block1; end
                if (out_valid2 && lat2 == 0) begin lat2 = n; ob2 = out_block2; end
                if (out_valid4 && lat4 == 0) begin lat4 = n; ob4 = out_block4; end
                step();
                n++;
            end
            check("sweep_lat1", 64'(lat1), 64'd34);
            check("sweep_lat2", 64'(lat2), 64'd50);
            check("sweep_lat4", 64'(lat4), 64'd82);
            check("sweep_blk1", ob1, expA);
            check("sweep_blk2", ob2, expA);
            check("sweep_blk4", ob4, expA);
            repeat (5) step();
        end

        // Backpressure with a stray in_valid pulse while DUT1 sits in DONE.
        out_ready = 1'b0;
        blk = 64'h0123456789abcdef;
        expA = golden(blk, 1'b0);
        runOne(blk, n);
        check("bp_latency", 64'(n), 64'd34);
        for (int c = 0; c < 10; c++) begin
            step();
            in_valid = (c == 4);
            in_block = 64'hfedcba9876543210;
            check("bp_block_stable", out_block1, expA);
            check("bp_in_ready_low", 64'(in_ready1), 64'd0);
        end
        in_valid = 1'b0;
        check("bp_out_valid_held", 64'(out_valid1), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_released_idle", 64'(in_ready1), 64'd1);
        check("bp_busy_clear", 64'(busy1), 64'd0);
        check("bp_out_valid_drop", 64'(out_valid1), 64'd0);
        repeat (100) step();

        // Reset mid-operation around round 7.
        in_block = 64'hdeadbeefcafef00d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (13) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_in_ready", 64'(in_ready1), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid1), 64'd0);
        check("mid_rst_busy", 64'(busy1), 64'd0);
        check("mid_rst_out_block", out_block1, 64'd0);
        check("mid_rst_f_in", 64'(f_in1), 64'd0);
        blk = 64'h00000001_80000000;
        runOne(blk, n);
        check("post_rst_latency", 64'(n), 64'd34);
        check("post_rst_block", out_block1, golden(blk, 1'b0));
        repeat (100) step();

        // Back-to-back: in_valid held high, out_ready=1.
        k = 0; m = 0; cyc = 0;
        in_block = {$urandom, $urandom};
        in_valid = 1'b1;
        while (m < 4 && cyc < 300) begin
            if (out_valid1) begin
                check("b2b_block", out_block1, expQ[m]);
                m++;
            end
            if (in_valid && in_ready1 && k < 4) begin
                acc[k] = cyc;
                expQ[k] = golden(in_block, 1'b0);
                k++;
            end
            step();
            cyc++;
            if (k == 4) in_valid = 1'b0;
            else in_block = {$urandom, $urandom};
        end
        check("b2b_count", 64'(m), 64'd4);
        for (int j = 1; j < 4; j++)
            check("b2b_spacing", 64'(acc[j] - acc[j-1]), 64'd35);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
